// File: rtl/shared_memory_arbiter_pkg.sv
// Shared constants and helpers for the shared-memory arbiter slice.
// Holds the default core count, bus widths and the contention-detect helper.
package shared_memory_arbiter_pkg;

    localparam int DEFAULT_NUM_CORES  = 4;
    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DATA_WIDTH         = 16;

    localparam logic [15:0] CONTENTION_MAX = 16'hFFFF;

    // True when at least two bits of the (zero-extended) request vector are set.
    function automatic logic multi_bit_set(input logic [15:0] vec);
        return ((vec & (vec - 16'd1)) != 16'd0);
    endfunction

endpackage

// File: rtl/shared_memory_arbiter_if.sv
// Per-core request bus and shared memory port bundled as one interface.
// The slave modport is the arbiter's view; master is the cores plus memory.
interface shared_memory_arbiter_if #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 16
) ();

    logic [NUM_CORES-1:0]            core_request;
    logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr;
    logic [NUM_CORES-1:0]            core_wren;
    logic [NUM_CORES-1:0]            core_rden;
    logic [NUM_CORES*16-1:0]         core_write_val;
    logic [NUM_CORES-1:0]            core_enable;
    logic [15:0]                     core_read_val;

    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic                            mem_wren;
    logic                            mem_rden;
    logic [15:0]                     mem_write_val;
    logic [15:0]                     mem_read_val;

    modport slave (
        input  core_request, core_addr, core_wren, core_rden, core_write_val,
        input  mem_read_val,
        output core_enable, core_read_val,
        output mem_addr, mem_wren, mem_rden, mem_write_val
    );

    modport master (
        output core_request, core_addr, core_wren, core_rden, core_write_val,
        output mem_read_val,
        input  core_enable, core_read_val,
        input  mem_addr, mem_wren, mem_rden, mem_write_val
    );

endinterface

// File: rtl/shared_memory_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] request,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    int                 cand_s;
    logic [IDX_W-1:0]   cand_idx_s;
    logic               take_s;

    // Scan NUM_CORES candidates starting just after the previous winner.
    always_comb begin
        grant       = {NUM_CORES{1'b0}};
        grant_idx   = {IDX_W{1'b0}};
        grant_valid = 1'b0;
        cand_s      = 0;
        cand_idx_s  = {IDX_W{1'b0}};
        take_s      = 1'b0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand_s             = (int'(last_grant) + i) % NUM_CORES;
            cand_idx_s         = IDX_W'(cand_s);
            take_s             = !grant_valid && request[cand_idx_s];
            grant[cand_idx_s]  = take_s;
            grant_idx          = take_s ? cand_idx_s : grant_idx;
            grant_valid        = grant_valid | take_s;
        end
    end

endmodule

// File: rtl/shared_memory_arbiter.sv
// Shared-memory responder: same-cycle round-robin grant, muxed memory port,
// one-cycle read return with hold, and a saturating contention counter.
module shared_memory_arbiter
    import shared_memory_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = DEFAULT_NUM_CORES,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    shared_memory_arbiter_if.slave bus,
    output logic [15:0]            contention_count
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [IDX_W-1:0]      last_grant_r;
    logic                  rd_pending_r;
    logic [15:0]           read_hold_r;
    logic [15:0]           contention_r;

    logic [NUM_CORES-1:0]  grant_oh_s;
    logic [IDX_W-1:0]      grant_idx_s;
    logic                  grant_valid_s;
    logic                  grant_live_s;
    logic                  contended_s;

    logic [NUM_CORES-1:0]  core_enable_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic                  mem_wren_s;
    logic                  mem_rden_s;
    logic [DATA_WIDTH-1:0] mem_write_val_s;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .request     (bus.core_request),
        .last_grant  (last_grant_r),
        .grant       (grant_oh_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Reset gates the grant directly so an asserted reset_n kills the bus at once.
    assign grant_live_s = grant_valid_s & reset_n;
    assign contended_s  = multi_bit_set(16'(bus.core_request));

    // Route the winning core onto the shared port; park the port when idle.
    always_comb begin
        core_enable_s   = {NUM_CORES{1'b0}};
        mem_addr_s      = {ADDR_WIDTH{1'b0}};
        mem_wren_s      = 1'b0;
        mem_rden_s      = 1'b0;
        mem_write_val_s = {DATA_WIDTH{1'b0}};
        if (grant_live_s) begin
            core_enable_s   = grant_oh_s;
            mem_addr_s      = bus.core_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wren_s      = bus.core_wren[grant_idx_s];
            mem_rden_s      = bus.core_rden[grant_idx_s];
            mem_write_val_s = bus.core_write_val[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            core_enable_s   = {NUM_CORES{1'b0}};
            mem_rden_s      = 1'b0;
        end
    end

    assign bus.core_enable   = core_enable_s;
    assign bus.mem_addr      = mem_addr_s;
    assign bus.mem_wren      = mem_wren_s;
    assign bus.mem_rden      = mem_rden_s;
    assign bus.mem_write_val = mem_write_val_s;

    // Fresh data straight from memory in the return cycle, otherwise the last value.
    assign bus.core_read_val = rd_pending_r ? bus.mem_read_val : read_hold_r;
    assign contention_count  = contention_r;

    // Round-robin pointer; idle cycles keep it so fairness survives gaps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_r <= IDX_W'(NUM_CORES - 1);
        end else if (grant_valid_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Read return tracking and hold register for the broadcast read bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_r <= 1'b0;
            read_hold_r  <= 16'h0000;
        end else begin
            rd_pending_r <= mem_rden_s;
            if (rd_pending_r) begin
                read_hold_r <= bus.mem_read_val;
            end else begin
                read_hold_r <= read_hold_r;
            end
        end
    end

    // Saturating count of cycles where two or more cores compete.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            contention_r <= 16'h0000;
        end else if (contended_s && (contention_r != CONTENTION_MAX)) begin
            contention_r <= contention_r + 16'd1;
        end else begin
            contention_r <= contention_r;
        end
    end

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Directed bench for shared_memory_arbiter with a small synchronous SRAM model.
module tb_shared_memory_arbiter;

    logic        clk;
    logic        reset_n;
    logic [15:0] contention_count;
    logic [15:0] mem_array [0:255];

    int tests_run;
    int fail_count;

    shared_memory_arbiter_if #(.NUM_CORES(4), .ADDR_WIDTH(16)) bus ();

    shared_memory_arbiter #(.NUM_CORES(4), .ADDR_WIDTH(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bus              (bus),
        .contention_count (contention_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: write commits at the edge, read data valid next cycle.
    always @(posedge clk) begin
        if (bus.mem_wren) mem_array[bus.mem_addr[7:0]] <= bus.mem_write_val;
        if (bus.mem_rden) bus.mem_read_val <= mem_array[bus.mem_addr[7:0]];
    end

    // Cores must never present a write and a read together.
    always @(negedge clk) begin
        assert (!(|(bus.core_request & bus.core_wren & bus.core_rden))) else begin
            fail_count++;
            $error("FAIL wr_rd_both observed=%b expected=0000", bus.core_request & bus.core_wren & bus.core_rden);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic req, input logic wr, input logic rd,
                            input logic [15:0] addr, input logic [15:0] wdata);
        bus.core_request[i]          = req;
        bus.core_wren[i]             = wr;
        bus.core_rden[i]             = rd;
        bus.core_addr[i*16 +: 16]    = addr;
        bus.core_write_val[i*16 +: 16] = wdata;
    endtask

    task automatic clear_all();
        bus.core_request   = 4'b0000;
        bus.core_wren      = 4'b0000;
        bus.core_rden      = 4'b0000;
        bus.core_addr      = 64'h0;
        bus.core_write_val = 64'h0;
    endtask

    initial begin
        logic [3:0] exp_en;
        tests_run  = 0;
        fail_count = 0;
        reset_n    = 1'b0;
        clear_all();
        bus.core_request = 4'b1111;

        // Reset with everyone requesting
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_enable", 32'(bus.core_enable), 32'h0);
        check("rst_count", 32'(contention_count), 32'h0);
        check("rst_read_val", 32'(bus.core_read_val), 32'h0);
        step();
        reset_n = 1'b1;

        // Round-robin 0,1,2,3,0 with counter tracking
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_en = 4'b0001 << (k % 4);
            check("rr_all_enable", 32'(bus.core_enable), 32'(exp_en));
            check("rr_all_count", 32'(contention_count), 32'(k));
            step();
        end

        // Idle: port parked
        clear_all();
        @(negedge clk);
        check("idle_enable", 32'(bus.core_enable), 32'h0);
        check("idle_mem_wren", 32'(bus.mem_wren), 32'h0);
        check("idle_mem_addr", 32'(bus.mem_addr), 32'h0);
        step();

        // Core 2 write then read back
        set_core(2, 1'b1, 1'b1, 1'b0, 16'h4010, 16'h1234);
        @(negedge clk);
        check("wr_enable", 32'(bus.core_enable), 32'h4);
        check("wr_mem_wren", 32'(bus.mem_wren), 32'h1);
        check("wr_mem_addr", 32'(bus.mem_addr), 32'h4010);
        check("wr_mem_wval", 32'(bus.mem_write_val), 32'h1234);
        step();
        set_core(2, 1'b1, 1'b0, 1'b1, 16'h4010, 16'h0000);
        @(negedge clk);
        check("rd_enable", 32'(bus.core_enable), 32'h4);
        check("rd_mem_rden", 32'(bus.mem_rden), 32'h1);
        check("rd_mem_wren", 32'(bus.mem_wren), 32'h0);
        step();
        clear_all();
        @(negedge clk);
        check("rd_return", 32'(bus.core_read_val), 32'h1234);
        check("rd_count", 32'(contention_count), 32'h5);
        step();

        // Preload A/B, then back-to-back reads from cores 0 and 1
        set_core(0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'hAAAA);
        step();
        clear_all();
        set_core(1, 1'b1, 1'b1, 1'b0, 16'h0030, 16'hBBBB);
        step();
        clear_all();
        set_core(0, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000);
        @(negedge clk);
        check("b2b_enable0", 32'(bus.core_enable), 32'h1);
        step();
        clear_all();
        set_core(1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000);
        @(negedge clk);
        check("b2b_enable1", 32'(bus.core_enable), 32'h2);
        check("b2b_read_a", 32'(bus.core_read_val), 32'hAAAA);
        step();
        clear_all();
        @(negedge clk);
        check("b2b_read_b", 32'(bus.core_read_val), 32'hBBBB);
        step();
        @(negedge clk);
        check("hold_read_b", 32'(bus.core_read_val), 32'hBBBB);
        step();

        // Cores 1 and 3 alternate after a grant to core 3
        set_core(3, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        check("alt_pre_enable", 32'(bus.core_enable), 32'h8);
        step();
        set_core(1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_en = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            check("alt_enable", 32'(bus.core_enable), 32'(exp_en));
            step();
        end
        clear_all();
        @(negedge clk);
        check("alt_count", 32'(contention_count), 32'h9);
        step();

        // Saturation: 9 + 65525 = 16'hFFFE, then pinned at 16'hFFFF
        bus.core_request = 4'b1111;
        repeat (65525) step();
        @(negedge clk);
        check("sat_below", 32'(contention_count), 32'hFFFE);
        step();
        @(negedge clk);
        check("sat_reach", 32'(contention_count), 32'hFFFF);
        repeat (4473) step();
        @(negedge clk);
        check("sat_hold", 32'(contention_count), 32'hFFFF);
        step();

        // Reset in the return cycle of a core-2 read
        clear_all();
        set_core(2, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
        @(negedge clk);
        check("mr_enable", 32'(bus.core_enable), 32'h4);
        check("mr_hold_before", 32'(bus.core_read_val), 32'hBBBB);
        step();
        check("mr_return", 32'(bus.core_read_val), 32'h1234);
        set_core(3, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        reset_n = 1'b0;
        #1;
        check("mr_rst_enable", 32'(bus.core_enable), 32'h0);
        check("mr_rst_read_val", 32'(bus.core_read_val), 32'h0);
        check("mr_rst_count", 32'(contention_count), 32'h0);
        check("mr_rst_mem_rden", 32'(bus.mem_rden), 32'h0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_enable", 32'(bus.core_enable), 32'h4);
        check("post_rst_read_val", 32'(bus.core_read_val), 32'h0);
        step();
        @(negedge clk);
        check("post_rst_enable2", 32'(bus.core_enable), 32'h8);
        check("post_rst_return", 32'(bus.core_read_val), 32'h1234);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/shared_memory_arbiter.md
# shared_memory_arbiter

Responder side of the per-core external memory bus: arbitrates the `core_request` lines of NUM_CORES cores, returns a same-cycle `core_enable` grant to exactly one, and drives a single shared synchronous-SRAM/device port. Read data returns to all cores one cycle after the grant. It sits at top level between the core array and the shared memory. It also keeps a saturating contention counter for performance tuning.

## Interface
- NUM_CORES, 4: number of requesting cores (2..16).
- ADDR_WIDTH, 16: bus address width.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- core_request  in  NUM_CORES  per-core request, held by the core until granted.
- core_addr  in  NUM_CORES*ADDR_WIDTH  flattened addresses; core i at bits [i*16+:16].
- core_wren  in  NUM_CORES  per-core write enable.
- core_rden  in  NUM_CORES  per-core read enable.
- core_write_val  in  NUM_CORES*16  flattened write data.
- core_enable  out  NUM_CORES  one-hot grant, combinational from the current requests.
- core_read_val  out  16  read data broadcast to all cores.
- mem_addr  out  ADDR_WIDTH  shared port address.
- mem_wren  out  1  shared port write strobe.
- mem_rden  out  1  shared port read strobe.
- mem_write_val  out  16  shared port write data.
- mem_read_val  in  16  shared port read data, valid the cycle after `mem_rden`.
- contention_count  out  16  saturating count of cycles with ≥2 requests.

## Operation
- Round-robin arbitration with registered pointer `last_grant` (reset = NUM_CORES-1, so core 0 wins first).
- Each cycle, search begins at `last_grant+1` and wraps modulo NUM_CORES. The first requester found is granted.
- `last_grant` updates only in cycles with a grant. Idle cycles leave it unchanged.
- `core_enable` is set only for the granted core. All bits are 0 with no request or while reset_n=0.
- Granted core's addr, wren, rden and write_val are muxed to `mem_*`.
  - No grant: `mem_wren`=`mem_rden`=0, `mem_addr`=0, `mem_write_val`=0.
- Unrequested cores never see `core_enable`=1.
- If wren and rden are both set, both are passed through unchanged. This case is illegal from a core and is flagged by a bench assertion only.
- Read return uses register `rd_pending` (reset 0), set to `mem_rden` each cycle.
  - `rd_pending`=1: `core_read_val` = `mem_read_val`, and the value is captured into `read_hold`.
  - `rd_pending`=0: `core_read_val` = `read_hold` (reset 0).
- `contention_count` increments when popcount(`core_request`) ≥ 2 and saturates at 16'hFFFF. Reset value is 0.

## Timing
- Grant latency is 0 cycles. A request in cycle N with a free or won bus gets `core_enable` in cycle N, so the core does not stall.
- A write commits at the clk edge ending cycle N.
- Read data is on `core_read_val` in cycle N+1, matching the core's one-cycle-delayed data select.
- Back-to-back grants are allowed every cycle, including a read followed by a read from another core. Each read's data appears exactly in the cycle after its own grant.
- Worst-case wait with all cores requesting is NUM_CORES-1 cycles.
- A single continuous requester is granted every cycle.
- Reset mid-operation: asserting reset_n=0 asynchronously clears `last_grant`, `rd_pending`, `read_hold` and `contention_count`, and forces `core_enable`=0.
  - A read issued in the cycle before reset returns no data.
  - The first grant after reset release goes to the lowest-index requester.
- No combinational path from `mem_read_val` to `core_enable`.

## Structure
- NUM_CORES default and the shared-memory address window constants go in `config.v`, alongside the other system constants.
- Sub-module `rr_arbiter`:
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant, grant index, grant_valid.
  - Purely combinational.
- The pointer register, data muxes, read-return logic and counter live in the top module.

## Test plan
- Reset with all four cores requesting, release: cycle 0 grants core 0, then cores 1, 2, 3, 0 in order; `contention_count` increments every cycle.
- Core 2 alone writes 16'h1234 to 16'h4010 → `core_enable`=4'b0100 same cycle, `mem_wren`=1, `mem_addr`=16'h4010. A following core 2 read returns 16'h1234 on `core_read_val` next cycle.
- Core 0 reads A (memory returns 16'hAAAA) and core 1 reads B (16'hBBBB) on consecutive grants → `core_read_val` is 16'hAAAA then 16'hBBBB on consecutive cycles. It then holds 16'hBBBB through idle cycles.
- Cores 1 and 3 request continuously after a grant to core 3 → grants alternate 1, 3, 1, 3. Cores 0 and 2 get no `core_enable`.
- Force `contention_count` near saturation with 70000 contended cycles → output stays at 16'hFFFF.
- Assert reset_n=0 mid-read: `core_enable`=0 immediately, `core_read_val`=0, counter is 0. The first post-reset grant goes to the lowest requesting index.
